// File: rtl/mii_tx_mac.sv
// Per-port MII egress transmitter: drains a FWFT byte/delimiter FIFO and sends
// preamble, data, zero pad up to MIN_FRAME, CRC-32 FCS and the inter-frame gap.
module mii_tx_mac #(
  parameter int MIN_FRAME   = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_del,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  output logic [3:0]  mii_txd,
  output logic        mii_txen,
  output logic        mii_txer,
  output logic        busy,
  output logic [15:0] tx_frames,
  output logic [7:0]  tx_underruns
);

  // state    | meaning
  // S_IDLE   | wait for a frame; discard lone delimiters; emits first preamble nibble
  // S_PRE    | remaining 14 preamble nibbles then SFD
  // S_DATA   | phase 0 pops a byte (low nibble out), phase 1 sends high nibble
  // S_PAD    | zero bytes through the CRC until MIN_FRAME reached
  // S_FCS    | FCS nibbles 1..7 (nibble 0 leaves with the last data/pad slot)
  // S_ABORT  | count the underrun; the tx_er nibble is already on the wire
  // S_DRAIN  | discard the rest of the frame up to its delimiter
  // S_IFG    | IFG_NIBBLES idle cycles
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_ABORT, S_DRAIN, S_IFG
  } state_t;

  localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        phase;
  logic [3:0]  data_hi;
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic [31:0] fcs;
  logic        pad_needed;

  logic        rden_c;
  logic [3:0]  txd_d;
  logic        txen_d;
  logic        txer_d;
  logic        byte_upd;
  logic [7:0]  upd_byte;
  logic        frame_done;
  logic        underrun;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign fcs        = ~crc;
  assign pad_needed = (byte_cnt < MIN_CNT);
  assign busy       = (state != S_IDLE);
  assign fifo_rden  = rden_c & ~arst;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!fifo_empty && !fifo_del) state_nx = S_PRE;
      S_PRE:   if (cnt == 8'd15) state_nx = S_DATA;
      S_DATA: begin
        if (!phase) begin
          if (fifo_empty)    state_nx = S_ABORT;
          else if (fifo_del) state_nx = pad_needed ? S_PAD : S_FCS;
        end
      end
      S_PAD:   if (!phase && !pad_needed) state_nx = S_FCS;
      S_FCS:   if (cnt == 8'd7) state_nx = S_IFG;
      S_ABORT: state_nx = S_DRAIN;
      S_DRAIN: if (!fifo_empty && fifo_del) state_nx = S_IFG;
      S_IFG:   if (cnt == IFG_LAST) state_nx = S_IDLE;
      default: state_nx = S_IFG;
    endcase
  end

  // Every byte slot decides its wire nibble here so txen never gaps between
  // preamble, data, pad and FCS.
  always_comb begin
    rden_c     = 1'b0;
    txd_d      = 4'h0;
    txen_d     = 1'b0;
    txer_d     = 1'b0;
    byte_upd   = 1'b0;
    upd_byte   = 8'h00;
    frame_done = 1'b0;
    underrun   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (fifo_del) begin
            rden_c = 1'b1;
          end else begin
            txen_d = 1'b1;
            txd_d  = 4'h5;
          end
        end
      end
      S_PRE: begin
        txen_d = 1'b1;
        txd_d  = (cnt == 8'd15) ? 4'hD : 4'h5;
      end
      S_DATA, S_PAD: begin
        txen_d = 1'b1;
        if (phase) begin
          txd_d = data_hi;
        end else if (state == S_DATA && fifo_empty) begin
          txer_d = 1'b1;
        end else if (state == S_DATA && !fifo_del) begin
          rden_c   = 1'b1;
          txd_d    = fifo_dout[3:0];
          byte_upd = 1'b1;
          upd_byte = fifo_dout;
        end else begin
          rden_c = (state == S_DATA);
          if (pad_needed) byte_upd = 1'b1;
          else            txd_d    = fcs[3:0];
        end
      end
      S_FCS: begin
        txen_d     = 1'b1;
        txd_d      = fcs[4*cnt[2:0] +: 4];
        frame_done = (cnt == 8'd7);
      end
      S_ABORT: underrun = 1'b1;
      S_DRAIN: rden_c = !fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mii_txd      <= 4'h0;
      mii_txen     <= 1'b0;
      mii_txer     <= 1'b0;
      cnt          <= 8'd0;
      phase        <= 1'b0;
      data_hi      <= 4'h0;
      crc          <= 32'hFFFFFFFF;
      byte_cnt     <= 11'd0;
      tx_frames    <= 16'd0;
      tx_underruns <= 8'd0;
    end else begin
      mii_txd  <= txd_d;
      mii_txen <= txen_d;
      mii_txer <= txer_d;

      if (state_nx != state)
        cnt <= (state_nx == S_PRE || state_nx == S_FCS) ? 8'd1 : 8'd0;
      else if (state == S_PRE || state == S_FCS || state == S_IFG)
        cnt <= cnt + 8'd1;

      phase <= (state_nx == S_DATA || state_nx == S_PAD) && byte_upd;

      if (state == S_PRE) begin
        crc      <= 32'hFFFFFFFF;
        byte_cnt <= 11'd0;
      end else if (byte_upd) begin
        crc     <= crc32_byte(crc, upd_byte);
        data_hi <= upd_byte[7:4];
        if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
      end

      if (frame_done) tx_frames <= tx_frames + 16'd1;
      if (underrun && tx_underruns != 8'hFF) tx_underruns <= tx_underruns + 8'd1;
    end
  end

endmodule

// File: tb/tb_mii_tx_mac.sv
// Bench for mii_tx_mac: FWFT FIFO model, expected-nibble scoreboard with an
// independent CRC residue check, frame vector table plus reset/back-to-back cases.
module tb_mii_tx_mac;

  logic        clk = 1'b0;
  logic        arst;
  logic [7:0]  fifo_dout;
  logic        fifo_del;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [3:0]  mii_txd;
  logic        mii_txen;
  logic        mii_txer;
  logic        busy;
  logic [15:0] tx_frames;
  logic [7:0]  tx_underruns;

  mii_tx_mac #(.MIN_FRAME(60), .IFG_NIBBLES(24)) dut (
    .clk(clk), .arst(arst),
    .fifo_dout(fifo_dout), .fifo_del(fifo_del), .fifo_empty(fifo_empty),
    .fifo_rden(fifo_rden),
    .mii_txd(mii_txd), .mii_txen(mii_txen), .mii_txer(mii_txer),
    .busy(busy), .tx_frames(tx_frames), .tx_underruns(tx_underruns)
  );

  always #20 clk = ~clk;

  typedef struct packed { logic del; logic [7:0] d; } word_t;

  typedef struct {
    int len; int kind; int cut; bit del_only;
    int exp_txen; int exp_pops; int exp_frames; int exp_under; int exp_lag;
  } vec_t;

  word_t      fifo_q[$];
  word_t      pend_q[$];
  logic [4:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, txen_cycles = 0, pop_cnt = 0;
  int last_pop_cyc = 0, busy_fall_cyc = 0;
  int last_gap = -1, cur_run = 0, frames_seen = 0;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Builds a frame, queues its words and the nibbles the wire must carry.
  task automatic push_frame(input int len, input int kind, input int cut);
    logic [7:0]  b[$];
    logic [31:0] c;
    logic [31:0] f;
    int          nb;
    for (int i = 0; i < len; i++) begin
      if (kind == 1) begin
        if (i < 6)        b.push_back(8'hFF);
        else if (i == 6)  b.push_back(8'h02);
        else if (i < 11)  b.push_back(8'h00);
        else if (i == 11) b.push_back(8'h01);
        else if (i == 12) b.push_back(8'h08);
        else if (i == 13) b.push_back(8'h00);
        else              b.push_back(8'(i - 14));
      end else begin
        b.push_back(8'((i * 37 + len * 5 + 3) & 255));
      end
    end
    for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, 4'h5});
    exp_q.push_back({1'b0, 4'hD});
    if (cut > 0) begin
      for (int i = 0; i < cut; i++) begin
        fifo_q.push_back('{del: 1'b0, d: b[i]});
        exp_q.push_back({1'b0, b[i][3:0]});
        exp_q.push_back({1'b0, b[i][7:4]});
      end
      exp_q.push_back({1'b1, 4'h0});
      for (int i = cut; i < len; i++) pend_q.push_back('{del: 1'b0, d: b[i]});
      pend_q.push_back('{del: 1'b1, d: 8'h00});
    end else begin
      for (int i = 0; i < len; i++) fifo_q.push_back('{del: 1'b0, d: b[i]});
      fifo_q.push_back('{del: 1'b1, d: 8'hA5});
      nb = (len < 60) ? 60 : len;
      c  = 32'hFFFFFFFF;
      for (int i = 0; i < nb; i++) begin
        logic [7:0] v;
        v = (i < len) ? b[i] : 8'h00;
        c = crc_step(c, v);
        exp_q.push_back({1'b0, v[3:0]});
        exp_q.push_back({1'b0, v[7:4]});
      end
      f = ~c;
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, f[4*k +: 4]});
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int stable;
    stable = 0;
    for (int i = 0; i < budget && stable < 3; i++) begin
      tick();
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy && !mii_txen) stable++;
      else stable = 0;
    end
    check({tag, "_settle"}, stable, 3);
    check({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  // Monitor + FWFT FIFO: sample away from the edge, apply pops just after it.
  initial begin
    logic       rd;
    logic [3:0] lo;
    logic [7:0] fb[$];
    logic [31:0] r;
    logic [4:0] e;
    int  nib_idx, gap, nib_err;
    bit  in_frame, bad, gap_valid, prev_busy;
    in_frame = 0; bad = 0; gap_valid = 0; prev_busy = 0;
    nib_idx = 0; gap = 0; nib_err = 0; lo = 4'h0;
    fifo_empty = 1'b1; fifo_del = 1'b0; fifo_dout = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      rd = 1'b0;
      if (arst) begin
        in_frame = 0; gap_valid = 0; prev_busy = 0; cur_run = 0;
        fb.delete();
      end else begin
        if (fifo_rden) begin
          rd = 1'b1;
          pop_cnt++;
          last_pop_cyc = cyc;
          check("rden_not_empty", fifo_empty, 0);
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
        if (mii_txen) begin
          txen_cycles++;
          if (!in_frame) begin
            in_frame = 1; bad = 0; nib_idx = 0; nib_err = 0; cur_run = 0;
            fb.delete();
            if (gap_valid) last_gap = gap;
          end
          cur_run++;
          if (exp_q.size() == 0) nib_err++;
          else begin
            e = exp_q.pop_front();
            if ({mii_txer, mii_txd} !== e) nib_err++;
          end
          if (mii_txer) bad = 1;
          if (nib_idx >= 16) begin
            if (nib_idx[0] == 1'b0) lo = mii_txd;
            else fb.push_back({mii_txd, lo});
          end
          nib_idx++;
        end else if (in_frame) begin
          in_frame = 0; gap = 1; gap_valid = 1; cur_run = 0;
          frames_seen++;
          check("frame_nibbles", nib_err, 0);
          if (!bad) begin
            r = 32'hFFFFFFFF;
            foreach (fb[i]) r = crc_step(r, fb[i]);
            check("crc_residue", bitrev32(r), 32'hC704DD7B);
          end
        end else begin
          gap++;
        end
      end
      @(posedge clk);
      #1;
      if (rd && !arst && fifo_q.size() > 0) fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0].d;
      fifo_del   = fifo_empty ? 1'b0  : fifo_q[0].del;
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   f0, i;
    vt[0] = '{64, 1, 0,  1'b0, 152, 65, 1, 0, 32};
    vt[1] = '{20, 0, 0,  1'b0, 144, 21, 2, 0, 0};
    vt[2] = '{0,  0, 0,  1'b1, 0,   1,  2, 0, 0};
    vt[3] = '{30, 0, 10, 1'b0, 37,  31, 2, 1, 25};
    vt[4] = '{60, 0, 0,  1'b0, 144, 61, 3, 1, 32};
    vt[5] = '{59, 0, 0,  1'b0, 144, 60, 4, 1, 0};
    vt[6] = '{61, 0, 0,  1'b0, 146, 62, 5, 1, 32};

    arst = 1'b1;
    repeat (3) tick();
    check("rst_txen", mii_txen, 0);
    check("rst_txd", mii_txd, 0);
    check("rst_txer", mii_txer, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", tx_frames, 0);
    check("rst_under", tx_underruns, 0);
    @(negedge clk); #5; arst = 1'b0;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      txen_cycles = 0; pop_cnt = 0; busy_fall_cyc = -1000;
      if (vt[v].del_only) fifo_q.push_back('{del: 1'b1, d: 8'h00});
      else push_frame(vt[v].len, vt[v].kind, vt[v].cut);
      if (vt[v].cut > 0) begin
        repeat (50) tick();
        check($sformatf("v%0d_drain_busy", v), busy, 1);
        check($sformatf("v%0d_txen_stall", v), mii_txen, 0);
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      end
      wait_idle(3000, $sformatf("v%0d", v));
      check($sformatf("v%0d_txen_cycles", v), txen_cycles, vt[v].exp_txen);
      check($sformatf("v%0d_pops", v), pop_cnt, vt[v].exp_pops);
      check($sformatf("v%0d_tx_frames", v), tx_frames, vt[v].exp_frames);
      check($sformatf("v%0d_tx_underruns", v), tx_underruns, vt[v].exp_under);
      if (vt[v].exp_lag > 0)
        check($sformatf("v%0d_ifg_lag", v), busy_fall_cyc - last_pop_cyc, vt[v].exp_lag);
    end

    // Two 60-byte frames queued back-to-back, reset during the second one.
    f0 = frames_seen;
    last_gap = -1;
    push_frame(60, 0, 0);
    push_frame(60, 0, 0);
    for (i = 0; i < 2000; i++) begin
      tick();
      if (frames_seen >= f0 + 1 && cur_run >= 40) break;
    end
    check("b2b_reach_data", i < 2000, 1);
    check("b2b_gap", last_gap, 24);
    check("b2b_frames", tx_frames, 6);

    @(negedge clk); #5;
    arst = 1'b1;
    #1;
    check("mid_rst_txen", mii_txen, 0);
    check("mid_rst_txd", mii_txd, 0);
    check("mid_rst_txer", mii_txer, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rden", fifo_rden, 0);
    check("mid_rst_frames", tx_frames, 0);
    check("mid_rst_under", tx_underruns, 0);
    fifo_q.delete();
    exp_q.delete();
    tick();
    check("mid_rst_txen_edge", mii_txen, 0);
    repeat (2) tick();
    txen_cycles = 0; pop_cnt = 0;
    push_frame(45, 0, 0);
    @(negedge clk); #5; arst = 1'b0;
    wait_idle(3000, "post_rst");
    check("post_rst_txen_cycles", txen_cycles, 144);
    check("post_rst_pops", pop_cnt, 46);
    check("post_rst_frames", tx_frames, 1);
    check("post_rst_under", tx_underruns, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_tx_mac.md
Name: mii_tx_mac

Overview:
- Per-port egress transmitter. Drains one switch output-port FIFO (byte + delimiter stream written by the switching core) and drives a 100 Mb/s MII transmit interface to the PHY.
- Adds preamble/SFD, pads short frames to 60 bytes, appends FCS (CRC-32) and enforces inter-frame gap.
- One instance per port, clocked by that port's MII TX clock (25 MHz, one nibble per cycle).

Parameters:
- MIN_FRAME, 60, minimum bytes (DA..payload+pad) before FCS; shorter frames zero-padded.
- IFG_NIBBLES, 24, idle cycles (txen=0) after each frame, including aborted frames.

Ports:
- clk  input  1  MII TX clock; all logic on rising edge.
- arst  input  1  asynchronous, active-high reset.
- fifo_dout  input  8  first-word-fall-through (FWFT) data, valid while fifo_empty=0.
- fifo_del  input  1  FWFT flag: current word is an end-of-frame delimiter (data ignored).
- fifo_empty  input  1  FIFO empty.
- fifo_rden  output  1  pop; combinational, one cycle per consumed word, never while fifo_empty=1.
- mii_txd  output  4  MII transmit nibble, registered.
- mii_txen  output  1  MII transmit enable, registered.
- mii_txer  output  1  MII transmit error, registered.
- busy  output  1  high in any state other than IDLE.
- tx_frames  output  16  completed good frames, wraps at 0xFFFF->0.
- tx_underruns  output  8  aborted frames, saturates at 0xFF.

Behaviour:
- Reset (async, any state): all outputs 0, counters 0, state IDLE, CRC register 0xFFFFFFFF. Mid-frame reset ends the frame immediately with txen=0 and no tx_er.
- Nibble order: low nibble of each byte first.
- IDLE:
  - fifo_empty=0 and fifo_del=1: pop the delimiter, no transmission, stay IDLE (empty frame discarded).
  - fifo_empty=0 and fifo_del=0: go PREAMBLE. Do not pop.
- PREAMBLE: 15 cycles txd=0x5, then 1 cycle txd=0xD (SFD), all with txen=1. Then DATA. CRC reset to 0xFFFFFFFF. Byte counter cleared.
- DATA, phase 0:
  - fifo_empty=0, fifo_del=0: latch byte, pop, update CRC, byte_cnt++. Next cycle drives low nibble, the following cycle the high nibble.
  - fifo_del=1: pop the delimiter. Go PAD if byte_cnt<MIN_FRAME, else FCS. The first PAD/FCS nibble follows the last data nibble with no gap.
  - fifo_empty=1: underrun; go ABORT.
- Bytes are consumed back-to-back, so txen is continuous from the first preamble nibble to the last FCS nibble.
- byte_cnt: 11 bits, saturating. No maximum-length check.
- PAD: send 0x00 bytes (2 nibbles each) through the CRC until byte_cnt=MIN_FRAME, then FCS.
- FCS:
  - fcs = ~crc, where crc uses reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB-first update.
  - Send 8 nibbles, fcs[3:0] first through fcs[31:28] last.
  - Then tx_frames++ and go IFG.
- ABORT:
  - One cycle with txen=1, txer=1, txd=0.
  - tx_underruns++ (saturating).
  - Then DRAIN.
- DRAIN: txen=0. Pop words as available, discarding them, until the delimiter is popped; wait while empty. Then IFG.
- IFG: txen=0, txer=0, txd=0 for IFG_NIBBLES cycles. Then IDLE. FIFO not read in IFG.
- Outside DATA/PAD/FCS/PREAMBLE/ABORT: txd=0, txen=0.
- tx_frames and tx_underruns never increment in the same cycle.
- Minimum frame on wire: 16 + 2·60 + 8 = 144 txen cycles. Next frame's preamble starts no earlier than IFG_NIBBLES+1 cycles after txen falls.
- Illegal state encoding: go IFG with txen=0.

Test Plan:
- Frame 1: 64 bytes DA=FF:FF:FF:FF:FF:FF, SA=02:00:00:00:00:01, type 0x0800, payload 0x00..0x31, then delimiter.
  - Required: txd=5×15 then D, data nibbles low-first, 8 FCS nibbles; 16+128+8=152 txen cycles.
  - CRC-32 over data+FCS gives residue 0xC704DD7B.
  - tx_frames=1. Exactly 64+1 fifo_rden pulses.
- Frame 2: 20-byte frame.
  - Required: 40 pad-zero bytes sent; 144 txen cycles; FCS computed over the 60 padded bytes; only 21 pops.
- Frame 3: delimiter-only word in IFG/IDLE.
  - Required: popped in IDLE, txen never asserted, counters unchanged.
- Frame 4: 30-byte frame with fifo_empty forced high after byte 10 for 50 cycles, remaining bytes plus delimiter supplied afterwards.
  - Required: one txen=1/txer=1 cycle right after byte 10's high nibble, then txen=0.
  - Remaining words plus delimiter popped; tx_underruns=1; tx_frames unchanged; 24-cycle IFG.
- Frame 5: two 60-byte frames queued back-to-back.
  - Required: exactly 24 txen=0 cycles between them, then the second preamble.
  - arst pulsed during the second frame's DATA: txen=0 on the next edge, all outputs 0, busy=0, and the next frame in the FIFO starts cleanly with a preamble after release.
